// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing constants and parity helper for the 16x4 FIFO controller.
// Targets a dual-port EBR that stores one parity bit alongside each data word.
package fifo_ctrl_pkg;

  localparam int DW        = 4;
  localparam int AW        = 4;
  localparam int DEPTH     = 2 ** AW;
  localparam int AFULL_LVL = 12;

  // Even parity: the returned bit makes the XOR of data plus parity equal to zero.
  function automatic logic even_par(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/fifo_ctrl_16x4_if.sv
// User-side push/pop/status bundle of the FIFO controller.
// The master modport belongs to the client and the slave modport to the controller.
interface fifo_ctrl_16x4_if #(
  parameter int DW = fifo_ctrl_pkg::DW,
  parameter int AW = fifo_ctrl_pkg::AW
);

  logic          Push;
  logic [DW-1:0] PushData;
  logic          Pop;
  logic [DW-1:0] PopData;
  logic          PopValid;
  logic          Full;
  logic          Empty;
  logic          AlmostFull;
  logic [AW:0]   Count;
  logic          Overflow;
  logic          Underflow;
  logic          ParityErr;
  logic          ClearErr;

  modport master (
    output Push, PushData, Pop, ClearErr,
    input  PopData, PopValid, Full, Empty, AlmostFull, Count,
           Overflow, Underflow, ParityErr
  );

  modport slave (
    input  Push, PushData, Pop, ClearErr,
    output PopData, PopValid, Full, Empty, AlmostFull, Count,
           Overflow, Underflow, ParityErr
  );

endinterface

// File: rtl/fifo_ctrl_16x4_ptr.sv
// Modulo-2**AW address pointer that advances by one on each enabled cycle.
// The wrap from the last address back to zero is the natural overflow of AW bits.
module fifo_ptr #(
  parameter int AW = fifo_ctrl_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_r;

  // Pointer register: hold or advance by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {AW{1'b0}};
    end else if (en) begin
      ptr_r <= ptr_r + AW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl_16x4.sv
// Synchronous FIFO controller for an external 16x4 dual-port EBR with a parity bit.
// Holds only pointers, occupancy and sticky error flags; the RAM sits beside it at top level.
module fifo_ctrl_16x4 #(
  parameter int DW        = fifo_ctrl_pkg::DW,
  parameter int AW        = fifo_ctrl_pkg::AW,
  parameter int AFULL_LVL = fifo_ctrl_pkg::AFULL_LVL
) (
  input  logic              Clock,
  input  logic              ResetN,
  fifo_ctrl_16x4_if.slave   bus,
  output logic [AW-1:0]     WrAddress,
  output logic [AW-1:0]     RdAddress,
  output logic [DW-1:0]     Data,
  output logic              EDI,
  output logic              WrEn,
  output logic              RdEn,
  input  logic [DW-1:0]     Q,
  input  logic              EDO
);

  import fifo_ctrl_pkg::*;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(2 ** AW);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [AW:0]   count_r;
  logic [AW:0]   count_nxt_s;
  logic [AW-1:0] wr_ptr_s;
  logic [AW-1:0] rd_ptr_s;
  logic          full_s;
  logic          empty_s;
  logic          wr_en_s;
  logic          rd_en_s;
  logic          par_bad_s;
  logic          pop_valid_r;
  logic          ovf_r;
  logic          udf_r;
  logic          perr_r;

  assign empty_s = (count_r == {(AW+1){1'b0}});
  assign full_s  = (count_r == FULL_CNT);

  // A full FIFO refuses writes even when a pop frees a slot in the same cycle,
  // so the RAM never sees a read and a write to one address together.
  assign wr_en_s = ResetN & bus.Push & ~full_s;
  assign rd_en_s = ResetN & bus.Pop  & ~empty_s;

  assign par_bad_s = pop_valid_r & (even_par(32'(Q)) ^ EDO);

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (Clock),
    .rst_n (ResetN),
    .en    (wr_en_s),
    .ptr   (wr_ptr_s)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (Clock),
    .rst_n (ResetN),
    .en    (rd_en_s),
    .ptr   (rd_ptr_s)
  );

  // Occupancy next-state: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + ONE_CNT;
      2'b01:   count_nxt_s = count_r - ONE_CNT;
      default: count_nxt_s = count_r;
    endcase
  end

  // Occupancy, read-valid pipeline stage and sticky error flags.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      count_r     <= {(AW+1){1'b0}};
      pop_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      udf_r       <= 1'b0;
      perr_r      <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      pop_valid_r <= rd_en_s;
      // A new error event outranks ClearErr arriving in the same cycle.
      ovf_r       <= (bus.Push & full_s)  | (ovf_r  & ~bus.ClearErr);
      udf_r       <= (bus.Pop  & empty_s) | (udf_r  & ~bus.ClearErr);
      perr_r      <= par_bad_s            | (perr_r & ~bus.ClearErr);
    end
  end

  assign WrEn      = wr_en_s;
  assign RdEn      = rd_en_s;
  assign WrAddress = wr_ptr_s;
  assign RdAddress = rd_ptr_s;
  assign Data      = bus.PushData;
  assign EDI       = even_par(32'(bus.PushData));

  assign bus.PopData    = Q;
  assign bus.PopValid   = pop_valid_r;
  assign bus.Count      = count_r;
  assign bus.Empty      = empty_s;
  assign bus.Full       = full_s;
  assign bus.AlmostFull = (count_r >= AF_CNT);
  assign bus.Overflow   = ovf_r;
  assign bus.Underflow  = udf_r;
  assign bus.ParityErr  = perr_r;

endmodule

// File: tb/tb_fifo_ctrl_16x4.sv
// Bench for fifo_ctrl_16x4: an EBR model with parity injection, a queue-based reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_fifo_ctrl_16x4;

  localparam int DW = 4;
  localparam int AW = 4;

  logic          Clock  = 1'b0;
  logic          ResetN = 1'b0;
  logic [AW-1:0] WrAddress;
  logic [AW-1:0] RdAddress;
  logic [DW-1:0] Data;
  logic          EDI;
  logic          WrEn;
  logic          RdEn;
  logic [DW-1:0] Q   = '0;
  logic          EDO = 1'b0;
  logic          inject = 1'b0;

  fifo_ctrl_16x4_if #(.DW(DW), .AW(AW)) bus ();

  fifo_ctrl_16x4 dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .bus       (bus),
    .WrAddress (WrAddress),
    .RdAddress (RdAddress),
    .Data      (Data),
    .EDI       (EDI),
    .WrEn      (WrEn),
    .RdEn      (RdEn),
    .Q         (Q),
    .EDO       (EDO)
  );

  always #5 Clock = ~Clock;

  // EBR model: 16 words of data plus parity, one-cycle registered read.
  logic [DW:0] mem [0:15];
  always @(posedge Clock) begin
    if (WrEn) mem[WrAddress] <= {EDI, Data};
    if (RdEn) begin
      Q   <= mem[RdAddress][DW-1:0];
      EDO <= mem[RdAddress][DW] ^ inject;
    end
  end

  int total = 0;
  int bad   = 0;
  bit in_rst = 1'b1;

  // Reference model: FIFO contents as a queue, pointers as running totals.
  logic [DW-1:0] mq [$];
  int            wr_tot, rd_tot;
  bit            m_pv, m_inj, m_ovf, m_udf, m_perr;
  logic [DW-1:0] m_pd;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    wr_tot = 0; rd_tot = 0;
    m_pv = 0; m_inj = 0; m_ovf = 0; m_udf = 0; m_perr = 0; m_pd = '0;
  endtask

  task automatic model_check();
    int sz;
    bit full, empty;
    sz    = mq.size();
    full  = (sz == 16);
    empty = (sz == 0);
    chk("count", int'(bus.Count), sz);
    chk("empty", int'(bus.Empty), int'(empty));
    chk("full", int'(bus.Full), int'(full));
    chk("afull", int'(bus.AlmostFull), int'(sz >= 12));
    chk("wren", int'(WrEn), int'(bus.Push && !full));
    chk("rden", int'(RdEn), int'(bus.Pop && !empty));
    chk("wraddr", int'(WrAddress), wr_tot % 16);
    chk("rdaddr", int'(RdAddress), rd_tot % 16);
    chk("data", int'(Data), int'(bus.PushData));
    chk("edi", int'(EDI), int'(^bus.PushData));
    chk("popvalid", int'(bus.PopValid), int'(m_pv));
    if (m_pv) chk("popdata", int'(bus.PopData), int'(m_pd));
    chk("overflow", int'(bus.Overflow), int'(m_ovf));
    chk("underflow", int'(bus.Underflow), int'(m_udf));
    chk("parityerr", int'(bus.ParityErr), int'(m_perr));
  endtask

  task automatic model_step();
    int sz;
    bit full, empty, wacc, racc, n_perr;
    sz     = mq.size();
    full   = (sz == 16);
    empty  = (sz == 0);
    wacc   = bus.Push && !full;
    racc   = bus.Pop && !empty;
    n_perr = (m_pv && m_inj) || (m_perr && !bus.ClearErr);
    m_ovf  = (bus.Push && full) || (m_ovf && !bus.ClearErr);
    m_udf  = (bus.Pop && empty) || (m_udf && !bus.ClearErr);
    m_perr = n_perr;
    m_pv   = racc;
    m_inj  = racc && inject;
    if (racc) begin
      m_pd = mq.pop_front();
      rd_tot++;
    end
    if (wacc) begin
      mq.push_back(bus.PushData);
      wr_tot++;
    end
  endtask

  // Compare process: check mid-cycle, advance the model at the clock edge.
  always begin
    @(negedge Clock);
    #3;
    if (!in_rst) model_check();
    @(posedge Clock);
    if (!in_rst) model_step();
  end

  task automatic drive(input bit p, input logic [DW-1:0] d, input bit pp,
                       input bit clr, input bit inj);
    @(negedge Clock);
    bus.Push = p; bus.PushData = d; bus.Pop = pp; bus.ClearErr = clr; inject = inj;
  endtask

  task automatic after_edge();
    @(posedge Clock);
    #2;
  endtask

  task automatic idle_inputs();
    bus.Push = 1'b0; bus.PushData = '0; bus.Pop = 1'b0; bus.ClearErr = 1'b0; inject = 1'b0;
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    ResetN = 1'b0;
    idle_inputs();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;
    model_clear();
    in_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int thr;
    idle_inputs();
    model_clear();
    do_reset();
    #1;
    chk("rst_count", int'(bus.Count), 0);
    chk("rst_empty", int'(bus.Empty), 1);
    chk("rst_full", int'(bus.Full), 0);
    chk("rst_afull", int'(bus.AlmostFull), 0);
    chk("rst_popvalid", int'(bus.PopValid), 0);

    // Four pushes then four pops: data returns in order one cycle after each pop.
    for (int k = 1; k <= 4; k++) drive(1'b1, DW'(k), 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      after_edge();
      chk("seq_pv", int'(bus.PopValid), 1);
      chk("seq_pd", int'(bus.PopData), k);
      chk("seq_par", int'(^{bus.PopData, EDO}), 0);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("seq_empty", int'(bus.Empty), 1);
    chk("seq_count", int'(bus.Count), 0);
    chk("seq_pv_off", int'(bus.PopValid), 0);

    // Fill to 16: AlmostFull from the 12th push, then a rejected 17th push.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
      after_edge();
      chk("fill_afull", int'(bus.AlmostFull), int'(i >= 12));
      chk("fill_count", int'(bus.Count), i);
    end
    chk("fill_full", int'(bus.Full), 1);
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    #1 chk("push17_wren", int'(WrEn), 0);
    after_edge();
    chk("push17_ovf", int'(bus.Overflow), 1);
    chk("push17_count", int'(bus.Count), 16);
    drive(1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
    #1 chk("fullpp_wren", int'(WrEn), 0);
    chk("fullpp_rden", int'(RdEn), 1);
    after_edge();
    chk("fullpp_count", int'(bus.Count), 15);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("clr_ovf", int'(bus.Overflow), 0);
    for (int i = 0; i < 15; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Pop on empty with simultaneous push.
    drive(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
    #1 chk("udf_rden", int'(RdEn), 0);
    chk("udf_wren", int'(WrEn), 1);
    after_edge();
    chk("udf_flag", int'(bus.Underflow), 1);
    chk("udf_count", int'(bus.Count), 1);

    // Corrupted parity on a read raises ParityErr one cycle after PopValid.
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    after_edge();
    chk("perr_pv", int'(bus.PopValid), 1);
    chk("perr_pd", int'(bus.PopData), 9);
    chk("perr_early", int'(bus.ParityErr), 0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("perr_set", int'(bus.ParityErr), 1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("perr_clr", int'(bus.ParityErr), 0);
    chk("udf_clr", int'(bus.Underflow), 0);

    // Random interleaved traffic in phases biased toward filling, draining and balance.
    for (int c = 0; c < 600; c++) begin
      case ((c / 60) % 3)
        0:       thr = 85;
        1:       thr = 15;
        default: thr = 50;
      endcase
      drive($urandom_range(0, 99) < thr, DW'($urandom),
            $urandom_range(0, 99) < (100 - thr),
            $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1 chk("wrapped", int'(wr_tot > 16), 1);

    // Reset while seven entries are held and a pop is in flight.
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, DW'(i + 2), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    @(posedge Clock);
    #1;
    in_rst = 1'b1;
    ResetN = 1'b0;
    #1;
    chk("mrst_pv", int'(bus.PopValid), 0);
    chk("mrst_count", int'(bus.Count), 0);
    chk("mrst_empty", int'(bus.Empty), 1);
    chk("mrst_full", int'(bus.Full), 0);
    chk("mrst_wren", int'(WrEn), 0);
    chk("mrst_rden", int'(RdEn), 0);
    @(negedge Clock);
    idle_inputs();
    ResetN = 1'b1;
    model_clear();
    in_rst = 1'b0;
    drive(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    #1 chk("mrst_waddr", int'(WrAddress), 0);
    chk("mrst_wren_after", int'(WrEn), 1);
    after_edge();
    chk("mrst_count_after", int'(bus.Count), 1);

    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
